fp32_accum: RTL and testbench

FP32_ACCUM -- requirements
Module: fp32_accum

---
 rtl/fp32_accum.sv | 179 +++++++++++++++++
 tb/tb_fp32_accum.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_accum.sv
// fp32_accum: streaming fp32 sum reduction around an external pipelined adder.
// Define FP32_ACCUM_CHECK_EN to build the adder-latency checker behind error_out.
module fp32_accum #(
  parameter int ADD_LATENCY = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [15:0] count_in,
  input  logic        data_valid_in,
  input  logic [31:0] data_in,
  output logic        data_ready_out,
  output logic        add_valid_out,
  output logic [31:0] add_a_out,
  output logic [31:0] add_b_out,
  input  logic        add_valid_in,
  input  logic [31:0] add_c_in,
  output logic        sum_valid_out,
  output logic [31:0] sum_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int LW = $clog2(ADD_LATENCY + 1);
  localparam logic [LW-1:0] LAT = LW'(ADD_LATENCY);
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REDUCE,
    DONE
  } state_t;

  state_t        state;
  logic [15:0]   cnt_n;
  logic [15:0]   acc_cnt;
  logic [15:0]   acc_nxt;
  logic [LW-1:0] iss_cnt;
  logic [LW-1:0] iss_nxt;
  logic [LW-1:0] live;
  logic [31:0]   stash;
  logic          have;
  logic [31:0]   sum_q;
  logic          sum_v;

  logic in_acc;
  logic in_red;
  logic hs;
  logic acc_exit;
  logic red_ret;
  logic red_pair;
  logic red_last;

  assign in_acc = (state == ACCUM);
  assign in_red = (state == REDUCE);

  assign data_ready_out = in_acc && (acc_cnt < cnt_n);
  assign hs = data_ready_out && data_valid_in;

  assign acc_nxt = acc_cnt + 16'(hs);
  assign iss_nxt = (iss_cnt == LAT) ? LAT : iss_cnt + ONE;
  assign acc_exit = in_acc && (acc_nxt == cnt_n) && (iss_nxt == LAT);

  assign red_ret  = in_red && add_valid_in;
  assign red_pair = red_ret && have;
  assign red_last = red_ret && !have && (live == ONE);

  assign sum_valid_out = sum_v;
  assign sum_out       = sum_q;
  assign busy_out      = (state != IDLE);

  // Adder issue: slot rotation in ACCUM, stash pairing in REDUCE.
  always_comb begin
    add_valid_out = 1'b0;
    add_a_out     = '0;
    add_b_out     = '0;
    unique case (1'b1)
      in_acc: begin
        add_valid_out = 1'b1;
        add_a_out     = (iss_cnt == LAT) ? add_c_in : '0;
        add_b_out     = hs ? data_in : '0;
      end
      red_pair: begin
        add_valid_out = 1'b1;
        add_a_out     = stash;
        add_b_out     = add_c_in;
      end
      default: ;
    endcase
  end

  // Control FSM, counters, stash and result register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      cnt_n   <= '0;
      acc_cnt <= '0;
      iss_cnt <= '0;
      live    <= '0;
      stash   <= '0;
      have    <= 1'b0;
      sum_q   <= '0;
      sum_v   <= 1'b0;
    end else begin
      sum_v <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            cnt_n   <= count_in;
            acc_cnt <= '0;
            iss_cnt <= '0;
            have    <= 1'b0;
            sum_q   <= '0;
            if (count_in == 16'd0) begin
              sum_v <= 1'b1;
              state <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_cnt <= acc_nxt;
          iss_cnt <= iss_nxt;
          if (acc_exit) begin
            live  <= LAT;
            have  <= 1'b0;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (red_last) begin
            sum_q <= add_c_in;
            sum_v <= 1'b1;
            state <= DONE;
          end else if (red_pair) begin
            have <= 1'b0;
            live <= live - ONE;
          end else if (red_ret) begin
            stash <= add_c_in;
            have  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FP32_ACCUM_CHECK_EN
  logic [ADD_LATENCY-1:0] iss_sr;
  logic                   err_q;
  logic                   chk_on;

  assign chk_on    = in_acc || in_red;
  assign error_out = err_q;

  // Issue history; a result must return exactly ADD_LATENCY cycles later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      iss_sr <= '0;
      err_q  <= 1'b0;
    end else begin
      iss_sr <= (iss_sr << 1) | ADD_LATENCY'(add_valid_out);
      if (chk_on && (add_valid_in != iss_sr[ADD_LATENCY-1])) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_fp32_accum.sv
// tb_fp32_accum: fp32_accum paired with an ideal fp32 adder model.
// Expected sums go into a scoreboard queue and are popped on sum_valid_out.
module tb_fp32_accum;

  logic        clk_in;
  logic        rst_n_in;
  logic        start_in;
  logic [15:0] count_in;
  logic        data_valid_in;
  logic [31:0] data_in;
  logic        data_ready_out;
  logic        add_valid_out;
  logic [31:0] add_a_out;
  logic [31:0] add_b_out;
  logic        add_valid_in;
  logic [31:0] add_c_in;
  logic        sum_valid_out;
  logic [31:0] sum_out;
  logic        busy_out;
  logic        error_out;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_issue = 0;
  int lat = 8;
  bit sb_off = 1'b0;
  logic mdl_rst;
  logic [31:0] exp_q[$];

  fp32_accum #(.ADD_LATENCY(8)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start_in       (start_in),
    .count_in       (count_in),
    .data_valid_in  (data_valid_in),
    .data_in        (data_in),
    .data_ready_out (data_ready_out),
    .add_valid_out  (add_valid_out),
    .add_a_out      (add_a_out),
    .add_b_out      (add_b_out),
    .add_valid_in   (add_valid_in),
    .add_c_in       (add_c_in),
    .sum_valid_out  (sum_valid_out),
    .sum_out        (sum_out),
    .busy_out       (busy_out),
    .error_out      (error_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic        vp[16];
  logic [31:0] dp[16];

  always @(posedge clk_in) begin
    if (mdl_rst) begin
      for (int i = 0; i < 16; i++) begin
        vp[i] <= 1'b0;
        dp[i] <= '0;
      end
    end else begin
      for (int i = 15; i > 0; i--) begin
        vp[i] <= vp[i-1];
        dp[i] <= dp[i-1];
      end
      vp[0] <= add_valid_out;
      dp[0] <= r2f(f2r(add_a_out) + f2r(add_b_out));
    end
  end

  assign add_valid_in = vp[lat-1];
  assign add_c_in     = dp[lat-1];

  always @(negedge clk_in) begin
    if (add_valid_out) n_issue++;
    if (sum_valid_out) begin
      n_pulse++;
      if (!sb_off) begin
        check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("sum", sum_out, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while (busy_out && i < 300) begin
      @(posedge clk_in); #1;
      i++;
    end
    check({nm, "_idle"}, {31'd0, busy_out}, 32'd0);
  endtask

  task automatic feed(input int n, input logic [31:0] vals[$],
                      input bit rnd, output int got);
    int cyc;
    bit acc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      data_valid_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_in = vals[got];
      @(negedge clk_in);
      acc = data_ready_out && data_valid_in;
      @(posedge clk_in); #1;
      if (acc) got++;
      cyc++;
    end
    data_valid_in = 1'b0;
    data_in = '0;
  endtask

  task automatic run_sum(input string nm, input int n,
                         input logic [31:0] vals[$], input bit rnd,
                         input logic [31:0] exp, input int exp_iss);
    int got, p0, i0;
    p0 = n_pulse;
    i0 = n_issue;
    start_in = 1'b1;
    count_in = 16'(n);
    exp_q.push_back(exp);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check({nm, "_rdy_hi"}, {31'd0, data_ready_out}, 32'd1);
    feed(n, vals, rnd, got);
    check({nm, "_acc"}, got, n);
    check({nm, "_rdy_lo"}, {31'd0, data_ready_out}, 32'd0);
    wait_idle(nm);
    check({nm, "_pulses"}, n_pulse - p0, 32'd1);
    check({nm, "_hold"}, sum_out, exp);
    check({nm, "_err"}, {31'd0, error_out}, 32'd0);
    if (exp_iss >= 0) check({nm, "_issues"}, n_issue - i0, exp_iss);
    @(posedge clk_in); #1;
  endtask

  task automatic pulse_reset();
    rst_n_in = 1'b0;
    #2;
    check("rst_ctl", {27'd0, data_ready_out, add_valid_out, sum_valid_out,
                      busy_out, error_out}, 32'd0);
    check("rst_sum", sum_out, 32'd0);
    check("rst_ops", add_a_out | add_b_out, 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  logic [31:0] v[$];
  logic        exp_err;
  int          got;
  int          p0;
  int          i0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n_in = 1'b0;
    mdl_rst = 1'b1;
    start_in = 1'b0;
    count_in = '0;
    data_valid_in = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_ctl", {27'd0, data_ready_out, add_valid_out, sum_valid_out,
                      busy_out, error_out}, 32'd0);
    check("rst_sum", sum_out, 32'd0);
    check("rst_ops", add_a_out | add_b_out, 32'd0);
    rst_n_in = 1'b1;
    mdl_rst = 1'b0;
    @(posedge clk_in); #1;

    v = '{32'h3F800000};
    run_sum("n1", 1, v, 1'b0, 32'h3F800000, 15);

    v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    run_sum("n4", 4, v, 1'b0, 32'h41200000, 15);

    v = {};
    for (int i = 0; i < 16; i++) v.push_back(32'h3F800000);
    run_sum("n16", 16, v, 1'b1, 32'h41800000, -1);

    v = '{32'h80000000, 32'h80000000, 32'h80000000};
    run_sum("negz", 3, v, 1'b0, 32'h00000000, 15);

    p0 = n_pulse;
    i0 = n_issue;
    start_in = 1'b1;
    count_in = 16'd0;
    exp_q.push_back(32'h0);
    @(negedge clk_in);
    check("n0_early", {31'd0, sum_valid_out}, 32'd0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("n0_pulse", {31'd0, sum_valid_out}, 32'd1);
    check("n0_sum", sum_out, 32'h0);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    @(posedge clk_in); #1;
    check("n0_busy", {31'd0, busy_out}, 32'd0);
    check("n0_pulses", n_pulse - p0, 32'd1);
    check("n0_issues", n_issue - i0, 32'd0);

    v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    start_in = 1'b1;
    count_in = 16'd4;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    feed(4, v, 1'b0, got);
    repeat (6) @(posedge clk_in);
    #1;
    check("red_busy", {30'd0, busy_out, data_ready_out}, 32'd2);
    pulse_reset();
    v = '{32'h3FC00000, 32'h40200000};
    run_sum("post_rst", 2, v, 1'b0, 32'h40800000, 15);

`ifdef FP32_ACCUM_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    lat = 9;
    sb_off = 1'b1;
    v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    start_in = 1'b1;
    count_in = 16'd4;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    feed(4, v, 1'b0, got);
    wait_idle("lat9");
    check("lat9_err", {31'd0, error_out}, {31'd0, exp_err});
    repeat (5) @(posedge clk_in);
    #1;
    check("lat9_hold", {31'd0, error_out}, {31'd0, exp_err});
    pulse_reset();
    check("err_clr", {31'd0, error_out}, 32'd0);
    lat = 8;
    sb_off = 1'b0;

    repeat (20) @(posedge clk_in);
    #1;
    check("sb_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
